video_cpu_arbiter: RTL and testbench



---
 rtl/video_pkg.sv | 16 +
 rtl/video_cpu_arbiter_bus_strobe_sync.sv | 38 +++
 rtl/video_cpu_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_video_cpu_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// video_pkg: shared FSM state type and default CPU slot timing
// for the video RAM CPU arbiter.
package video_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_DONE
  } arb_state_e;

  localparam int SEQ_PERIOD_DEF = 32;
  localparam int SLOT_START_DEF = 17;
  localparam int SLOT_END_DEF   = 20;

endpackage

// File: rtl/video_cpu_arbiter_bus_strobe_sync.sv
// bus_strobe_sync: two-flop synchroniser for an active-low ISA
// strobe, plus falling-edge (assertion) detect.
// Ports: clk, reset (sync, active-high), strobe_l (raw, active-low),
//        active (synchronised strobe asserted), fall (one-clock pulse).
module bus_strobe_sync (
  input  logic clk,
  input  logic reset,
  input  logic strobe_l,
  output logic active,
  output logic fall
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;
  logic prev_d, prev_q;

  always_comb begin
    meta_d = strobe_l;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign active = ~sync_q;
  assign fall   = prev_q & ~sync_q;

endmodule

// File: rtl/video_cpu_arbiter.sv
// video_cpu_arbiter: slots CPU ISA memory cycles into the display
// sequencer's CPU window on the shared VRAM and inserts ISA wait states.
// Ports: clk/reset (sync, active-high); clk_seq sequencer phase;
//   ISA side bus_a, bus_mem_cs, bus_memr_l, bus_memw_l, bus_d in,
//   bus_out, bus_dir, bus_rdy out; VRAM side cpu_grant, cpu_ram_a,
//   ram_we_l out, ram_d in; snow/snow_data to the pixel pipeline.
// Build option: define CGA_SNOW_EN to generate CGA write snow;
//   otherwise snow and snow_data are tied low.
module video_cpu_arbiter
  import video_pkg::*;
#(
  parameter int ADDR_WIDTH   = 15,
  parameter int SEQ_PERIOD   = SEQ_PERIOD_DEF,
  parameter int SLOT_START   = SLOT_START_DEF,
  parameter int SLOT_END     = SLOT_END_DEF,
  parameter int USE_BUS_WAIT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4:0]            clk_seq,
  input  logic [ADDR_WIDTH-1:0] bus_a,
  input  logic                  bus_mem_cs,
  input  logic                  bus_memr_l,
  input  logic                  bus_memw_l,
  input  logic [7:0]            bus_d,
  output logic [7:0]            bus_out,
  output logic                  bus_dir,
  output logic                  bus_rdy,
  input  logic                  hres_mode,
  input  logic                  display_enable,
  output logic                  cpu_grant,
  output logic [ADDR_WIDTH-1:0] cpu_ram_a,
  output logic                  ram_we_l,
  input  logic [7:0]            ram_d,
  output logic                  snow,
  output logic [7:0]            snow_data
);

  localparam logic [4:0] SEQ_LAST  = 5'(SEQ_PERIOD - 1);
  localparam logic [4:0] SEQ_OPEN  = 5'(SLOT_START);
  localparam logic [4:0] SEQ_CLOSE = 5'(SLOT_END);

  logic rd_act, rd_fall;
  logic wr_act, wr_fall;
  logic req, start_slot, wait_req;
  logic [4:0] seq_nxt;

  arb_state_e state_d, state_q;
  logic [ADDR_WIDTH-1:0] addr_d, addr_q;
  logic [7:0] wdata_d, wdata_q;
  logic [7:0] rdata_d, rdata_q;
  logic is_rd_d, is_rd_q;
  logic grant_d, grant_q;
  logic we_l_d, we_l_q;

  bus_strobe_sync u_rd_sync (
    .clk      (clk),
    .reset    (reset),
    .strobe_l (bus_memr_l),
    .active   (rd_act),
    .fall     (rd_fall)
  );

  bus_strobe_sync u_wr_sync (
    .clk      (clk),
    .reset    (reset),
    .strobe_l (bus_memw_l),
    .active   (wr_act),
    .fall     (wr_fall)
  );

  assign req = bus_mem_cs & (rd_fall | wr_fall);

  // Phase of the next cycle; grant is registered, so the slot is
  // opened one clock early to be high while clk_seq == SLOT_START.
  assign seq_nxt = (clk_seq == SEQ_LAST) ? 5'd0 : clk_seq + 5'd1;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    is_rd_d    = is_rd_q;
    grant_d    = grant_q;
    we_l_d     = we_l_q;
    start_slot = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = bus_a;
          wdata_d = bus_d;
          is_rd_d = rd_fall;
          if (seq_nxt == SEQ_OPEN) start_slot = 1'b1;
          else state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (seq_nxt == SEQ_OPEN) start_slot = 1'b1;
      end
      ST_ACCESS: begin
        if (clk_seq == SEQ_CLOSE) begin
          state_d = ST_DONE;
          grant_d = 1'b0;
          we_l_d  = 1'b1;
          if (is_rd_q) rdata_d = ram_d;
        end
      end
      ST_DONE: begin
        if (!rd_act && !wr_act) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (start_slot) begin
      state_d = ST_ACCESS;
      grant_d = 1'b1;
      we_l_d  = is_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      is_rd_q <= 1'b0;
      grant_q <= 1'b0;
      we_l_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      is_rd_q <= is_rd_d;
      grant_q <= grant_d;
      we_l_q  <= we_l_d;
    end
  end

  // Raw strobes so the wait state appears with no sync delay.
  assign wait_req = ~reset & bus_mem_cs
                  & (~bus_memr_l | ~bus_memw_l)
                  & (state_q != ST_DONE);

  assign bus_rdy   = (USE_BUS_WAIT != 0) ? ~wait_req : 1'b1;
  assign bus_dir   = bus_mem_cs & ~bus_memr_l;
  assign bus_out   = rdata_q;
  assign cpu_grant = grant_q;
  assign ram_we_l  = we_l_q;
  assign cpu_ram_a = grant_q ? addr_q : '0;

`ifdef CGA_SNOW_EN
  logic       snow_d, snow_q;
  logic [7:0] snow_data_d, snow_data_q;

  always_comb begin
    snow_d      = start_slot & ~is_rd_d
                & hres_mode & display_enable;
    snow_data_d = snow_d ? wdata_d : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      snow_q      <= 1'b0;
      snow_data_q <= 8'h00;
    end else begin
      snow_q      <= snow_d;
      snow_data_q <= snow_data_d;
    end
  end

  assign snow      = snow_q;
  assign snow_data = snow_data_q;
`else
  logic unused_snow;
  assign unused_snow = hres_mode ^ display_enable;
  assign snow        = 1'b0;
  assign snow_data   = 8'h00;
`endif

endmodule

// File: tb/tb_video_cpu_arbiter.sv
// tb_video_cpu_arbiter: directed bench for video_cpu_arbiter with a
// transaction-level timing model checked every cycle.
module tb_video_cpu_arbiter;

`ifdef CGA_SNOW_EN
  localparam bit SNOW_ON = 1'b1;
`else
  localparam bit SNOW_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  clk_seq = 5'd0;
  logic [14:0] bus_a = '0;
  logic        cs = 1'b0;
  logic        memr_l = 1'b1;
  logic        memw_l = 1'b1;
  logic [7:0]  bus_d = '0;
  logic        hres = 1'b0;
  logic        de = 1'b0;
  logic [7:0]  ram_d = '0;

  logic [7:0]  bus_out, n_out;
  logic        bus_dir, n_dir;
  logic        bus_rdy, n_rdy;
  logic        cpu_grant, n_grant;
  logic [14:0] ram_a, n_ram_a;
  logic        we_l, n_we_l;
  logic        snow, n_snow;
  logic [7:0]  snow_data, n_snow_data;

  video_cpu_arbiter dut (
    .clk(clk), .reset(reset), .clk_seq(clk_seq),
    .bus_a(bus_a), .bus_mem_cs(cs),
    .bus_memr_l(memr_l), .bus_memw_l(memw_l),
    .bus_d(bus_d), .bus_out(bus_out), .bus_dir(bus_dir),
    .bus_rdy(bus_rdy), .hres_mode(hres),
    .display_enable(de), .cpu_grant(cpu_grant),
    .cpu_ram_a(ram_a), .ram_we_l(we_l), .ram_d(ram_d),
    .snow(snow), .snow_data(snow_data)
  );

  video_cpu_arbiter #(.USE_BUS_WAIT(0)) dut_nw (
    .clk(clk), .reset(reset), .clk_seq(clk_seq),
    .bus_a(bus_a), .bus_mem_cs(cs),
    .bus_memr_l(memr_l), .bus_memw_l(memw_l),
    .bus_d(bus_d), .bus_out(n_out), .bus_dir(n_dir),
    .bus_rdy(n_rdy), .hres_mode(hres),
    .display_enable(de), .cpu_grant(n_grant),
    .cpu_ram_a(n_ram_a), .ram_we_l(n_we_l), .ram_d(ram_d),
    .snow(n_snow), .snow_data(n_snow_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Transaction model: slot window in absolute cycle numbers.
  bit          m_valid = 1'b0;
  bit          m_rd = 1'b0;
  bit          m_snow = 1'b0;
  int          m_gs = 0;
  int          m_ge = 0;
  int          m_kill = 32'h3FFF_FFFF;
  logic [14:0] m_addr = '0;
  logic [7:0]  m_wd = '0;
  logic [7:0]  mbus_out = 8'h00;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d seq=%0d got=%h want=%h",
               nm, cyc, clk_seq, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      bit live, in_win, act, e_rdy, e_snow;
      live = m_valid && (cyc < m_kill);
      if (cyc == m_kill) mbus_out = 8'h00;
      in_win = live && cyc >= m_gs && cyc <= m_ge;
      act = cs && (!memr_l || !memw_l);
      e_rdy = !act || reset || (live && cyc > m_ge);
      e_snow = SNOW_ON && live && m_snow && cyc == m_gs;
      check("grant", 32'(cpu_grant), 32'(in_win));
      check("we_l", 32'(we_l), 32'(!(in_win && !m_rd)));
      check("rdy", 32'(bus_rdy), 32'(e_rdy));
      check("dir", 32'(bus_dir), 32'(cs && !memr_l));
      check("bus_out", 32'(bus_out), 32'(mbus_out));
      check("snow", 32'(snow), 32'(e_snow));
      check("snow_data", 32'(snow_data),
            32'(e_snow ? m_wd : 8'h00));
      if (in_win) check("ram_a", 32'(ram_a), 32'(m_addr));
      check("nw_rdy", 32'(n_rdy), 32'd1);
      check("nw_grant", 32'(n_grant), 32'(in_win));
      check("nw_we_l", 32'(n_we_l),
            32'(!(in_win && !m_rd)));
      if (live && m_rd && cyc == m_ge) mbus_out = ram_d;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    clk_seq = 5'(cyc % 32);
  endtask

  task automatic wait_seq(input int s);
    int n = 0;
    while (int'(clk_seq) != s && n < 80) begin
      tick();
      n++;
    end
    check("wait_seq", 32'(clk_seq), 32'(s));
  endtask

  // Strobe falls in the current cycle: visible to the FSM two
  // clocks later, slot is the first phase-17 cycle after that.
  task automatic arm(input bit rd, input logic [14:0] a,
                     input logic [7:0] d);
    int t;
    t = cyc + 3;
    while (t % 32 != 17) t++;
    m_gs = t;
    m_ge = t + 3;
    m_rd = rd;
    m_addr = a;
    m_wd = d;
    m_snow = !rd && hres && de;
    m_kill = 32'h3FFF_FFFF;
    m_valid = 1'b1;
  endtask

  task automatic pins(input bit rd, input logic [14:0] a,
                      input logic [7:0] d);
    bit es;
    es = SNOW_ON && !rd && hres && de;
    if (cyc >= m_gs - 1 && cyc <= m_ge + 1) begin
      case (clk_seq)
        5'd16: check("p16_grant", 32'(cpu_grant), 32'd0);
        5'd17: begin
          check("p17_grant", 32'(cpu_grant), 32'd1);
          check("p17_addr", 32'(ram_a), 32'(a));
          check("p17_we_l", 32'(we_l), 32'(rd));
          check("p17_nw_we_l", 32'(n_we_l), 32'(rd));
          check("p17_snow", 32'(snow), 32'(es));
          check("p17_snow_d", 32'(snow_data),
                32'(es ? d : 8'h00));
        end
        5'd18: check("p18_snow", 32'(snow), 32'd0);
        5'd20: begin
          check("p20_grant", 32'(cpu_grant), 32'd1);
          check("p20_rdy", 32'(bus_rdy), 32'd0);
          check("p20_nw_rdy", 32'(n_rdy), 32'd1);
        end
        5'd21: begin
          check("p21_grant", 32'(cpu_grant), 32'd0);
          check("p21_we_l", 32'(we_l), 32'd1);
          check("p21_rdy", 32'(bus_rdy), 32'd1);
        end
        default: ;
      endcase
    end
  endtask

  task automatic access(input bit rd, input logic [14:0] a,
                        input logic [7:0] d, input int fseq,
                        input logic [7:0] exp_out);
    wait_seq(fseq);
    bus_a = a;
    bus_d = d;
    cs = 1'b1;
    if (rd) memr_l = 1'b0;
    else memw_l = 1'b0;
    arm(rd, a, d);
    #1;
    check("rdy_fall", 32'(bus_rdy), 32'd0);
    while (cyc < m_ge + 2) begin
      tick();
      pins(rd, a, d);
    end
    if (rd) check("rd_data", 32'(bus_out), 32'(exp_out));
    check("end_dir", 32'(bus_dir), 32'(rd));
    check("end_rdy", 32'(bus_rdy), 32'd1);
    memr_l = 1'b1;
    memw_l = 1'b1;
    repeat (6) tick();
    cs = 1'b0;
    tick();
  endtask

  initial begin
    repeat (4) tick();
    reset = 1'b0;
    check("rst_rdy", 32'(bus_rdy), 32'd1);
    check("rst_we_l", 32'(we_l), 32'd1);
    check("rst_grant", 32'(cpu_grant), 32'd0);
    check("rst_out", 32'(bus_out), 32'd0);
    check("rst_snow", 32'({snow, snow_data}), 32'd0);
    chk_en = 1'b1;

    access(1'b0, 15'h0123, 8'hA5, 2, 8'h00);

    ram_d = 8'h3C;
    access(1'b1, 15'h0456, 8'h00, 19, 8'h3C);
    ram_d = 8'h00;

    // Reset in the middle of a write slot.
    wait_seq(2);
    bus_a = 15'h0222;
    bus_d = 8'h99;
    cs = 1'b1;
    memw_l = 1'b0;
    arm(1'b0, 15'h0222, 8'h99);
    begin
      int n = 0;
      while ((clk_seq != 5'd18 || cyc < m_gs) && n < 80) begin
        tick();
        n++;
      end
    end
    check("mid_we_l", 32'(we_l), 32'd0);
    reset = 1'b1;
    memw_l = 1'b1;
    m_kill = cyc + 1;
    tick();
    check("kill_we_l", 32'(we_l), 32'd1);
    check("kill_grant", 32'(cpu_grant), 32'd0);
    check("kill_rdy", 32'(bus_rdy), 32'd1);
    check("kill_out", 32'(bus_out), 32'd0);
    reset = 1'b0;
    repeat (8) tick();
    cs = 1'b0;
    tick();

    hres = 1'b1;
    de = 1'b1;
    access(1'b0, 15'h7FFF, 8'h7E, 5, 8'h00);
    de = 1'b0;
    access(1'b0, 15'h0001, 8'h7E, 5, 8'h00);
    hres = 1'b0;

    // Strobe without the framebuffer decode hit.
    memw_l = 1'b0;
    repeat (40) begin
      tick();
      if (clk_seq == 5'd18) begin
        check("nocs_grant", 32'(cpu_grant), 32'd0);
        check("nocs_rdy", 32'(bus_rdy), 32'd1);
        check("nocs_we_l", 32'(we_l), 32'd1);
      end
    end
    memw_l = 1'b1;
    repeat (4) tick();

    access(1'b0, 15'h4000, 8'h5A, 30, 8'h00);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
